// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller: button debounce, preset editing, start/pause/resume
// state machine with its own prescaler, and a two-digit multiplexed 7-segment drive.
// Optional build macro: COUNTDOWN_BLINK_EN -- blinks the 00 display while in DONE.
`timescale 1ns/1ps

module countdown_ctrl #(
  parameter int unsigned DEB_CYC  = 20,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc1,
  input  logic       btn_inc10,
  input  logic       btn_start,
  input  logic       btn_clr,
  output logic [7:0] seg,
  output logic [7:0] cat,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC - 1);
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
`ifdef COUNTDOWN_BLINK_EN
  localparam logic [PreW-1:0] PreHalf = PreW'(TICK_DIV / 2);
`endif

  // Button lane order: 0 = inc1, 1 = inc10, 2 = start, 3 = clr
  typedef enum logic [1:0] {StSet, StRun, StPause, StDone} state_e;

  logic [3:0]      raw;
  logic [3:0]      meta_q, sync_q;
  logic [3:0]      lvl_q, lvl_d;
  logic [3:0]      prev_q;
  logic [3:0]      pulse_q;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  logic            clr_p, start_p, inc10_p, inc1_p;

  state_e          st_q, st_d;
  logic [3:0]      tens_q, tens_d, ones_q, ones_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            busy_q, done_q;

  logic            sel_q;
  logic [7:0]      seg_q, seg_d, cat_q, cat_d;
  logic [3:0]      digit;
  logic            blank;
  logic            last_step;

  assign raw = {btn_clr, btn_start, btn_inc10, btn_inc1};

  // Debounce counters: count while synced input disagrees with the level, flip on the last count
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          lvl_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Synchronizers, debounced levels and rising-edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      pulse_q <= lvl_q & ~prev_q;
      cnt_q   <= cnt_d;
    end
  end

  // Only the highest-priority pulse of a cycle is acted upon
  assign clr_p   = pulse_q[3];
  assign start_p = pulse_q[2] & ~pulse_q[3];
  assign inc10_p = pulse_q[1] & ~|pulse_q[3:2];
  assign inc1_p  = pulse_q[0] & ~|pulse_q[3:1];

  // Decrementing from 01 is the step that finishes the countdown
  assign last_step = (tens_q == 4'd0) && (ones_q == 4'd1);

  // Next-state, value and prescaler logic
  always_comb begin
    st_d    = st_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    if (clr_p) begin
      st_d    = StSet;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = '0;
    end else begin
      case (st_q)
        StSet: begin
          if (start_p) begin
            if ((tens_q != 4'd0) || (ones_q != 4'd0)) begin
              st_d    = StRun;
              presc_d = '0;
            end
          end else if (inc10_p) begin
            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
          end else if (inc1_p) begin
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end
        StRun: begin
          // The prescaler keeps counting on the edge that pauses, so paused time is exact
          if (presc_q == PreMax) begin
            presc_d = '0;
            if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
            if (last_step) begin
              st_d = StDone;
            end else if (start_p) begin
              st_d = StPause;
            end
          end else begin
            presc_d = presc_q + PreW'(1);
            if (start_p) begin
              st_d = StPause;
            end
          end
        end
        StPause: begin
          if (start_p) begin
            st_d = StRun;
          end
        end
        StDone: begin
`ifdef COUNTDOWN_BLINK_EN
          presc_d = (presc_q == PreMax) ? '0 : presc_q + PreW'(1);
`endif
          if (start_p) begin
            st_d    = StSet;
            presc_d = '0;
          end
        end
        default: st_d = StSet;
      endcase
    end
  end

  // State, value, prescaler and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StSet;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      busy_q  <= (st_d == StRun) || (st_d == StPause);
      done_q  <= (st_d == StDone);
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  // Second half of each prescaler period is the blank phase
  assign blank = (st_q == StDone) && (presc_q >= PreHalf);
`else
  assign blank = 1'b0;
`endif

  // Segment decode for the currently selected digit
  always_comb begin
    digit = sel_q ? tens_q : ones_q;
    case (digit)
      4'd0:    seg_d = 8'h3F;
      4'd1:    seg_d = 8'h06;
      4'd2:    seg_d = 8'h5B;
      4'd3:    seg_d = 8'h4F;
      4'd4:    seg_d = 8'h66;
      4'd5:    seg_d = 8'h6D;
      4'd6:    seg_d = 8'h7D;
      4'd7:    seg_d = 8'h07;
      4'd8:    seg_d = 8'h7F;
      4'd9:    seg_d = 8'h6F;
      default: seg_d = 8'h00;
    endcase
    cat_d = sel_q ? 8'hFD : 8'hFE;
    if (blank) begin
      seg_d = 8'h00;
      cat_d = 8'hFF;
    end
  end

  // Scan register: seg and cat update together, select toggles every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      seg_q <= 8'h00;
      cat_q <= 8'hFF;
    end else begin
      sel_q <= ~sel_q;
      seg_q <= seg_d;
      cat_q <= cat_d;
    end
  end

  assign seg  = seg_q;
  assign cat  = cat_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with DEB_CYC=4, TICK_DIV=10.
// A button driven right after edge E is acted on at edge E+8.
`timescale 1ns/1ps

module tb_countdown_ctrl;

  localparam int unsigned DebCyc  = 4;
  localparam int unsigned TickDiv = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'b0000;  // 0 inc1, 1 inc10, 2 start, 3 clr
  logic [7:0] seg, cat;
  logic       busy, done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [7:0] seg_lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  countdown_ctrl #(
    .DEB_CYC  (DebCyc),
    .TICK_DIV (TickDiv)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc1  (btn[0]),
    .btn_inc10 (btn[1]),
    .btn_start (btn[2]),
    .btn_clr   (btn[3]),
    .seg       (seg),
    .cat       (cat),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    ticks(10);
    btn[idx] = 1'b0;
    ticks(10);
  endtask

  function automatic int value();
    return int'(dut.tens_q) * 10 + int'(dut.ones_q);
  endfunction

  // Two scan cycles: expect both digits of v with matching cat
  task automatic check_disp(input int v);
    for (int k = 0; k < 2; k++) begin
      ticks(1);
      if (cat == 8'hFE) begin
        check("seg_ones", seg, seg_lut[v % 10]);
      end else begin
        check("cat_tens", cat, 8'hFD);
        check("seg_tens", seg, seg_lut[v / 10]);
      end
    end
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_seg", seg, 8'h00);
    check("rst_cat", cat, 8'hFF);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    check("first_seg", seg, 8'h3F);
    check("first_cat", cat, 8'hFE);
    ticks(1);
    check("second_cat", cat, 8'hFD);

    // Preset 23 with latency check on the first inc10
    btn[1] = 1'b1;
    ticks(7);
    check("inc10_lat_pre", value(), 0);
    ticks(1);
    check("inc10_lat", value(), 10);
    ticks(2);
    btn[1] = 1'b0;
    ticks(10);
    press(1);
    for (int i = 0; i < 3; i++) press(0);
    check("val_23", value(), 23);
    check_disp(23);
    check("busy_set", busy, 1'b0);

    // 99 + inc1 wraps to 00
    for (int i = 0; i < 7; i++) press(1);
    for (int i = 0; i < 6; i++) press(0);
    check("val_99", value(), 99);
    press(0);
    check("wrap_99", value(), 0);
    // 95 + inc10 keeps ones
    for (int i = 0; i < 9; i++) press(1);
    for (int i = 0; i < 5; i++) press(0);
    check("val_95", value(), 95);
    press(1);
    check("wrap_95", value(), 5);
    check_disp(5);

    // Countdown from 03
    press(3);
    check("clr_val", value(), 0);
    for (int i = 0; i < 3; i++) press(0);
    btn[2] = 1'b1;
    ticks(7);
    check("start_pre", busy, 1'b0);
    ticks(1);                          // R
    check("run_busy", busy, 1'b1);
    ticks(2);
    btn[2] = 1'b0;
    ticks(7);                          // R+9
    check("cd_r9", value(), 3);
    ticks(1);
    check("cd_r10", value(), 2);
    ticks(10);
    check("cd_r20", value(), 1);
    ticks(9);
    check("cd_r29_done", done, 1'b0);
    ticks(1);                          // R+30
    check("cd_r30_val", value(), 0);
    check("cd_r30_done", done, 1'b1);
    check("cd_r30_busy", busy, 1'b0);
    check_disp(0);
    btn[2] = 1'b1;
    ticks(8);
    check("ack_done", done, 1'b0);
    check("ack_busy", busy, 1'b0);
    ticks(2);
    btn[2] = 1'b0;
    ticks(10);

    // Pause/resume from 05: pause acts at R+15, resume at R+65, DONE at R+100
    press(3);
    for (int i = 0; i < 5; i++) press(0);
    btn[2] = 1'b1;
    ticks(8);                          // R
    check("p_run", busy, 1'b1);
    ticks(2);
    btn[2] = 1'b0;
    ticks(5);                          // R+7
    btn[2] = 1'b1;
    ticks(8);                          // R+15
    check("p_val15", value(), 4);
    ticks(2);
    btn[2] = 1'b0;
    ticks(23);                         // R+40
    check("p_val40", value(), 4);
    check("p_busy40", busy, 1'b1);
    ticks(17);                         // R+57
    btn[2] = 1'b1;
    ticks(7);                          // R+64
    check("p_val64", value(), 4);
    ticks(3);                          // R+67
    btn[2] = 1'b0;
    ticks(32);                         // R+99
    check("p_r99_done", done, 1'b0);
    ticks(1);                          // R+100 = D
    check("p_done", done, 1'b1);
    check("p_done_val", value(), 0);

    // Display in DONE
    ticks(5);                          // D+5
    check("dn5_seg", seg, 8'h3F);
    ticks(1);                          // D+6
`ifdef COUNTDOWN_BLINK_EN
    check("blink6_seg", seg, 8'h00);
    check("blink6_cat", cat, 8'hFF);
    ticks(4);
    check("blink10_seg", seg, 8'h00);
    ticks(1);
    check("blink11_seg", seg, 8'h3F);
`else
    check("steady6_seg", seg, 8'h3F);
    ticks(4);
    check("steady10_seg", seg, 8'h3F);
    ticks(1);
    check("steady11_seg", seg, 8'h3F);
`endif
    btn[2] = 1'b1;
    ticks(7);
    check("dn_ack_pre", done, 1'b1);
    ticks(1);
    check("dn_ack", done, 1'b0);
    ticks(2);
    btn[2] = 1'b0;
    ticks(10);

    // clr and inc1 pulses together in RUN
    press(0);
    press(0);
    btn[2] = 1'b1;
    ticks(8);                          // R
    check("pri_run", busy, 1'b1);
    ticks(2);
    btn[2] = 1'b0;
    ticks(8);                          // R+10, value 01
    check("pri_r10", value(), 1);
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    ticks(8);                          // R+18
    check("pri_busy", busy, 1'b0);
    check("pri_val", value(), 0);
    ticks(2);
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    ticks(10);
    check("pri_after", value(), 0);

    // Short glitch on start
    press(0);
    btn[2] = 1'b1;
    ticks(3);
    btn[2] = 1'b0;
    ticks(15);
    check("glitch_busy", busy, 1'b0);
    check("glitch_val", value(), 1);

    // Asynchronous reset mid-RUN
    btn[2] = 1'b1;
    ticks(8);
    check("rr_run", busy, 1'b1);
    ticks(2);
    btn[2] = 1'b0;
    ticks(3);
    rst_n = 1'b0;
    #1;
    check("rr_seg", seg, 8'h00);
    check("rr_cat", cat, 8'hFF);
    check("rr_busy", busy, 1'b0);
    check("rr_val", value(), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    check("rr_first_seg", seg, 8'h3F);
    check("rr_first_cat", cat, 8'hFE);
    ticks(20);
    check("rr_busy_after", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
